// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel, decode-side
// valid/ready channel, and the redirect/fault sideband to branch resolution.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, fetch_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  // Memory / decode / branch-resolution side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, fetch_fault,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues one imem request at a time,
// holds the returned word for decode, and squashes responses made stale by redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input logic          i_clk,
  input logic          i_rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic        kill_reg;
  logic        fault_reg;
  logic        req_reg;
  logic        valid_reg;

  logic redirect_ok;
  logic redirect_bad;

  assign redirect_ok  = bus.redirect && (bus.redirect_pc[1:0] == 2'b00);
  assign redirect_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = pc_reg;
  assign bus.inst_valid  = valid_reg;
  assign bus.inst        = inst_reg;
  assign bus.inst_pc     = inst_pc_reg;
  assign bus.opcode      = inst_reg[6:0];
  assign bus.fetch_fault = fault_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_ADDR;
      inst_reg    <= NOP_INST;
      inst_pc_reg <= RESET_ADDR;
      kill_reg    <= 1'b0;
      fault_reg   <= 1'b0;
      req_reg     <= 1'b0;
      valid_reg   <= 1'b0;
    end else if (state_reg == FAULT) begin
      // Terminal until reset; late responses and further redirects are ignored.
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (redirect_bad) begin
      state_reg <= FAULT;
      fault_reg <= 1'b1;
      kill_reg  <= 1'b0;
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
      inst_reg  <= NOP_INST;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect_ok) pc_reg <= bus.redirect_pc;
          state_reg <= REQ;
          req_reg   <= 1'b1;
        end

        REQ: begin
          if (redirect_ok) pc_reg <= bus.redirect_pc;
          if (bus.imem_gnt) begin
            // A redirect racing the grant turns the accepted request into a stale one.
            state_reg <= WAIT;
            req_reg   <= 1'b0;
            kill_reg  <= redirect_ok;
          end
        end

        WAIT: begin
          if (redirect_ok) pc_reg <= bus.redirect_pc;
          if (bus.imem_rvalid) begin
            if (redirect_ok || kill_reg) begin
              kill_reg  <= 1'b0;
              state_reg <= REQ;
              req_reg   <= 1'b1;
            end else begin
              inst_reg    <= bus.imem_rdata;
              inst_pc_reg <= pc_reg;
              state_reg   <= HOLD;
              valid_reg   <= 1'b1;
            end
          end else if (redirect_ok) begin
            kill_reg <= 1'b1;
          end
        end

        HOLD: begin
          // Redirect outranks consumption so the target is never skipped past.
          if (redirect_ok || bus.inst_ready) begin
            pc_reg    <= redirect_ok ? bus.redirect_pc : pc_reg + 32'd4;
            inst_reg  <= NOP_INST;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= REQ;
          end
        end

        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-configurable memory responder plus a
// scoreboard of the instructions decode should see, filled as responses are delivered.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_ADDR(32'h0), .NOP_INST(NOP)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          lat = 1;
  int          cnt = -1;
  logic [31:0] pend_addr = '0;
  logic [31:0] resp_addr = '0;
  logic        pend_killed = 1'b0;
  logic        resp_killed = 1'b0;
  logic        stale_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[24:0], 7'h33};
  endfunction

  function automatic exp_t peek();
    exp_t e;
    e.pc   = 32'hxxxx_xxxx;
    e.inst = 32'hxxxx_xxxx;
    if (exp_q.size() > 0) e = exp_q[0];
    return e;
  endfunction

  // One clock: record what the DUT sees at the edge, then advance the memory model.
  task automatic step();
    logic        granted;
    logic        redir_now;
    logic [31:0] gaddr;
    granted   = (bus.imem_req === 1'b1) && (bus.imem_gnt === 1'b1);
    redir_now = bus.redirect;
    gaddr     = bus.imem_addr;
    if (bus.imem_rvalid && !resp_killed && !redir_now)
      exp_q.push_back('{pc: resp_addr, inst: bus.imem_rdata});
    if ((bus.inst_valid === 1'b1) && (redir_now || bus.inst_ready) && exp_q.size() > 0)
      void'(exp_q.pop_front());
    if (cnt >= 0 && redir_now) pend_killed = 1'b1;
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (granted) begin
      cnt         = lat;
      pend_addr   = gaddr;
      pend_killed = redir_now;
    end
    if (cnt > 0) cnt--;
    if (cnt == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = stale_en ? 32'hDEAD_BEEF : mem_word(pend_addr);
      resp_addr       = pend_addr;
      resp_killed     = pend_killed;
      stale_en        = 1'b0;
      cnt             = -1;
    end
  endtask

  task automatic wait_valid(input string name, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.inst_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
      waited++;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: inst_valid=%b required 1 within 30 cycles", name, bus.inst_valid);
    end
  endtask

  task automatic test_reset();
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.inst_ready = 0; bus.redirect = 0; bus.redirect_pc = 0;
    rst_n = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.imem_req, bus.inst_valid, bus.fetch_fault} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: req/valid/fault=%b required 000", {bus.imem_req, bus.inst_valid, bus.fetch_fault});
    end
    tests_run++;
    if (bus.inst !== NOP || bus.opcode !== 7'h13) begin
      tests_failed++;
      $display("FAIL reset_inst: inst=%h opcode=%h required %h/13", bus.inst, bus.opcode, NOP);
    end
    tests_run++;
    if (bus.inst_pc !== 32'h0 || bus.imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_pc: inst_pc=%h addr=%h required 0/0", bus.inst_pc, bus.imem_addr);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_first_fetch();
    bit ok; int w; exp_t e;
    bus.imem_gnt = 1; lat = 1;
    rst_n = 1'b1;
    tests_run++;
    if (bus.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_idle_req: req=%b required 0", bus.imem_req);
    end
    step();
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL first_req: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
    step();
    tests_run++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_wait: req=%b valid=%b required 0/0", bus.imem_req, bus.inst_valid);
    end
    wait_valid("first_fetch", ok, w);
    if (ok) begin
      e = peek();
      tests_run++;
      if (bus.inst !== 32'h0050_0093 || bus.opcode !== 7'h13 || bus.inst_pc !== 32'h0 || e.inst !== 32'h0050_0093) begin
        tests_failed++;
        $display("FAIL first_hold: inst=%h opcode=%h pc=%h required 00500093/13/00000000", bus.inst, bus.opcode, bus.inst_pc);
      end
    end
    $display("[TB] first fetch: inst=%h pc=%h", bus.inst, bus.inst_pc);
  endtask

  task automatic test_stall();
    exp_t e;
    bus.inst_ready = 0;
    e = peek();
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== e.inst || bus.imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_%0d: valid=%b inst=%h req=%b required 1/%h/0", i, bus.inst_valid, bus.inst, bus.imem_req, e.inst);
      end
    end
    bus.inst_ready = 1;
    step();
    bus.inst_ready = 0;
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.inst_valid !== 1'b0 || bus.inst !== NOP) begin
      tests_failed++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b inst=%h required 1/00000004/0/%h", bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, NOP);
    end
    $display("[TB] stall released: next addr=%h", bus.imem_addr);
  endtask

  task automatic test_redirect_wait();
    bit ok; int w; exp_t e;
    lat = 3;
    step();
    bus.redirect = 1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 0;
    stale_en = 1;
    tests_run++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL redir_wait_pc: req=%b addr=%h required 0/00000100", bus.imem_req, bus.imem_addr);
    end
    step();
    tests_run++;
    if (bus.inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_wait_stale: valid=%b required 0", bus.inst_valid);
    end
    step();
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL redir_wait_reissue: req=%b addr=%h valid=%b queued=%0d required 1/00000100/0/0", bus.imem_req, bus.imem_addr, bus.inst_valid, exp_q.size());
    end
    lat = 1;
    wait_valid("redir_wait", ok, w);
    if (ok) begin
      e = peek();
      tests_run++;
      if (bus.inst_pc !== 32'h100 || bus.inst !== mem_word(32'h100) || bus.inst !== e.inst) begin
        tests_failed++;
        $display("FAIL redir_wait_hold: inst=%h pc=%h required %h/00000100", bus.inst, bus.inst_pc, mem_word(32'h100));
      end
    end
    $display("[TB] redirect in WAIT: inst=%h pc=%h", bus.inst, bus.inst_pc);
  endtask

  task automatic test_redirect_hold();
    bit ok; int w; exp_t e;
    bus.redirect = 1; bus.redirect_pc = 32'h20;
    step();
    bus.redirect = 0;
    tests_run++;
    if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h20 || bus.inst !== NOP) begin
      tests_failed++;
      $display("FAIL redir_hold_drop: valid=%b addr=%h inst=%h required 0/00000020/%h", bus.inst_valid, bus.imem_addr, bus.inst, NOP);
    end
    wait_valid("redir_hold", ok, w);
    if (ok) begin
      e = peek();
      tests_run++;
      if (bus.inst_pc !== 32'h20 || bus.inst !== e.inst) begin
        tests_failed++;
        $display("FAIL redir_hold_fetch: inst=%h pc=%h required %h/00000020", bus.inst, bus.inst_pc, e.inst);
      end
    end
    bus.redirect = 1; bus.redirect_pc = 32'h80; bus.inst_ready = 1;
    step();
    bus.redirect = 0; bus.inst_ready = 0;
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80 || bus.inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_ready_prio: req=%b addr=%h valid=%b required 1/00000080/0", bus.imem_req, bus.imem_addr, bus.inst_valid);
    end
    $display("[TB] redirect+ready in HOLD: next addr=%h", bus.imem_addr);
  endtask

  task automatic test_wrap();
    bit ok; int w; exp_t e;
    bus.redirect = 1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 0;
    step();
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_reissue: req=%b addr=%h required 1/fffffffc", bus.imem_req, bus.imem_addr);
    end
    wait_valid("wrap", ok, w);
    if (ok) begin
      e = peek();
      tests_run++;
      if (bus.inst_pc !== 32'hFFFF_FFFC || bus.inst !== mem_word(32'hFFFF_FFFC) || bus.inst !== e.inst) begin
        tests_failed++;
        $display("FAIL wrap_hold: inst=%h pc=%h required %h/fffffffc", bus.inst, bus.inst_pc, mem_word(32'hFFFF_FFFC));
      end
    end
    bus.inst_ready = 1;
    step();
    bus.inst_ready = 0;
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_addr: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
    wait_valid("wrap_zero", ok, w);
    if (ok) begin
      tests_run++;
      if (bus.inst_pc !== 32'h0 || bus.inst !== 32'h0050_0093) begin
        tests_failed++;
        $display("FAIL wrap_zero_hold: inst=%h pc=%h required 00500093/00000000", bus.inst, bus.inst_pc);
      end
    end
    $display("[TB] wrap: inst=%h pc=%h", bus.inst, bus.inst_pc);
  endtask

  task automatic test_back_to_back();
    bit ok; int w; exp_t e; logic [31:0] exp_pc;
    bus.inst_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      exp_pc = 32'(4 * k);
      step();
      wait_valid("b2b", ok, w);
      if (ok) begin
        e = peek();
        tests_run++;
        if (w != 2 || bus.inst_pc !== exp_pc || bus.inst !== mem_word(exp_pc) || e.pc !== exp_pc) begin
          tests_failed++;
          $display("FAIL b2b_%0d: gap=%0d pc=%h inst=%h required 2/%h/%h", k, w, bus.inst_pc, bus.inst, exp_pc, mem_word(exp_pc));
        end
        $display("[TB] back-to-back %0d: pc=%h inst=%h gap=%0d", k, bus.inst_pc, bus.inst, w);
      end
    end
    bus.inst_ready = 0;
  endtask

  task automatic test_fault();
    bus.redirect = 1; bus.redirect_pc = 32'h102;
    step();
    bus.redirect = 0;
    tests_run++;
    if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_enter: fault=%b req=%b valid=%b required 1/0/0", bus.fetch_fault, bus.imem_req, bus.inst_valid);
    end
    for (int i = 0; i < 5; i++) begin
      resp_killed = 1'b1;
      bus.imem_rvalid = (i == 1);
      bus.imem_rdata  = 32'hDEAD_BEEF;
      bus.redirect    = (i == 3);
      bus.redirect_pc = 32'h40;
      step();
      bus.redirect = 0;
      tests_run++;
      if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL fault_sticky_%0d: fault=%b req=%b valid=%b required 1/0/0", i, bus.fetch_fault, bus.imem_req, bus.inst_valid);
      end
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_reset: fault=%b req=%b required 0/0", bus.fetch_fault, bus.imem_req);
    end
    exp_q.delete();
    cnt = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL fault_recover: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
    $display("[TB] fault sticky until reset, recovered addr=%h", bus.imem_addr);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_back_to_back();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
